// File: rtl/align_shifter.sv
`default_nettype none
// ============================================================================
// Module   : align_shifter
// Brief    : Operand ordering and bit-serial mantissa alignment with G/R/S
//            generation for the single-precision adder front end.
// Revision : 1.0 - initial release
// ============================================================================
module align_shifter #(
  parameter int MAX_SHIFT = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  Ea,
  input  logic [23:0] Ma,
  input  logic [7:0]  Eb,
  input  logic [23:0] Mb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Er,
  output logic [23:0] M_large,
  output logic [23:0] M_small,
  output logic [2:0]  GRS,
  output logic        swap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] c_max_shift = 8'(MAX_SHIFT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_er;
  logic [7:0]  r_cnt;
  logic [23:0] r_m_large;
  logic [23:0] r_m_small;
  logic [2:0]  r_grs;
  logic        r_swap;

  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [7:0]  w_d;
  logic        w_swap;
  logic        w_accept;
  logic        w_absorb;
  logic [23:0] w_m_large;
  logic [23:0] w_m_small;

  // Denormals share the exponent of the smallest normal for ordering/distance.
  assign w_ea      = (Ea == 8'd0) ? 8'd1 : Ea;
  assign w_eb      = (Eb == 8'd0) ? 8'd1 : Eb;
  assign w_swap    = (w_eb > w_ea) || ((w_eb == w_ea) && (Mb > Ma));
  assign w_d       = w_swap ? (w_eb - w_ea) : (w_ea - w_eb);
  assign w_m_large = w_swap ? Mb : Ma;
  assign w_m_small = w_swap ? Ma : Mb;
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_absorb  = (w_d >= c_max_shift);

  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Er        = r_er;
  assign M_large   = r_m_large;
  assign M_small   = r_m_small;
  assign GRS       = r_grs;
  assign swap      = r_swap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ((w_d == 8'd0) || w_absorb) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 8'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_er      <= 8'd0;
      r_cnt     <= 8'd0;
      r_m_large <= 24'd0;
      r_m_small <= 24'd0;
      r_grs     <= 3'b000;
      r_swap    <= 1'b0;
    end else if (w_accept) begin
      r_er      <= w_swap ? Eb : Ea;
      r_cnt     <= w_d;
      r_m_large <= w_m_large;
      r_swap    <= w_swap;
      if (w_absorb) begin
        r_m_small <= 24'd0;
        r_grs     <= {2'b00, |w_m_small};
      end else begin
        r_m_small <= w_m_small;
        r_grs     <= 3'b000;
      end
    end else if (r_state == S_SHIFT) begin
      // Sticky accumulates whatever falls off the round position.
      r_grs     <= {r_m_small[0], r_grs[2], r_grs[1] | r_grs[0]};
      r_m_small <= r_m_small >> 1;
      r_cnt     <= r_cnt - 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_align_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_align_shifter
// Brief    : Directed, table-driven self-checking bench for align_shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_align_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Ea;
  logic [23:0] Ma;
  logic [7:0]  Eb;
  logic [23:0] Mb;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Er;
  logic [23:0] M_large;
  logic [23:0] M_small;
  logic [2:0]  GRS;
  logic        swap;

  int tests;
  int fails;

  typedef struct {
    logic [7:0]  ea;
    logic [23:0] ma;
    logic [7:0]  eb;
    logic [23:0] mb;
    logic        swp;
    logic [7:0]  er;
    logic [23:0] ml;
    logic [23:0] ms;
    logic [2:0]  grs;
    int          lat;
  } vec_t;

  localparam int c_nvec = 12;
  vec_t vecs[c_nvec];

  align_shifter #(.MAX_SHIFT(26)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ea        (Ea),
    .Ma        (Ma),
    .Eb        (Eb),
    .Mb        (Mb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Er        (Er),
    .M_large   (M_large),
    .M_small   (M_small),
    .GRS       (GRS),
    .swap      (swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input vec_t v, input string tag);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk($sformatf("%s in_ready_timeout", tag), 32'(in_ready), 32'd1);
    Ea = v.ea; Ma = v.ma; Eb = v.eb; Mb = v.mb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands: only the accept cycle may matter.
    Ea = 8'hA5; Ma = 24'h5A5A5A; Eb = 8'h3C; Mb = 24'hC3C3C3;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    launch(v, tag);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(v.lat));
    chk($sformatf("%s swap", tag), 32'(swap), 32'(v.swp));
    chk($sformatf("%s Er", tag), 32'(Er), 32'(v.er));
    chk($sformatf("%s M_large", tag), 32'(M_large), 32'(v.ml));
    chk($sformatf("%s M_small", tag), 32'(M_small), 32'(v.ms));
    chk($sformatf("%s GRS", tag), 32'(GRS), 32'(v.grs));
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Ea = 8'd0; Ma = 24'd0; Eb = 8'd0; Mb = 24'd0;

    //          ea     ma          eb     mb          swp   er     ml          ms          grs     lat
    vecs[0]  = '{8'h80, 24'hC00000, 8'h7F, 24'h800000, 1'b0, 8'h80, 24'hC00000, 24'h400000, 3'b000, 2};
    vecs[1]  = '{8'h7F, 24'h800001, 8'h82, 24'h800000, 1'b1, 8'h82, 24'h800000, 24'h100000, 3'b001, 4};
    vecs[2]  = '{8'h9E, 24'h800000, 8'h80, 24'h800003, 1'b0, 8'h9E, 24'h800000, 24'h000000, 3'b001, 1};
    vecs[3]  = '{8'h7F, 24'h800000, 8'h7F, 24'hA00000, 1'b1, 8'h7F, 24'hA00000, 24'h800000, 3'b000, 1};
    vecs[4]  = '{8'h00, 24'h400000, 8'h01, 24'h800000, 1'b1, 8'h01, 24'h800000, 24'h400000, 3'b000, 1};
    vecs[5]  = '{8'h98, 24'hFFFFFF, 8'h80, 24'hC00001, 1'b0, 8'h98, 24'hFFFFFF, 24'h000000, 3'b111, 25};
    vecs[6]  = '{8'h99, 24'h800000, 8'h80, 24'hC00001, 1'b0, 8'h99, 24'h800000, 24'h000000, 3'b011, 26};
    vecs[7]  = '{8'h9A, 24'h800000, 8'h80, 24'h800000, 1'b0, 8'h9A, 24'h800000, 24'h000000, 3'b001, 1};
    vecs[8]  = '{8'h00, 24'h000000, 8'h00, 24'h000000, 1'b0, 8'h00, 24'h000000, 24'h000000, 3'b000, 1};
    vecs[9]  = '{8'h85, 24'h800000, 8'h80, 24'hFFFFFF, 1'b0, 8'h85, 24'h800000, 24'h07FFFF, 3'b111, 6};
    vecs[10] = '{8'h82, 24'h800006, 8'h84, 24'h800000, 1'b1, 8'h84, 24'h800000, 24'h200001, 3'b100, 3};
    vecs[11] = '{8'h7F, 24'h800000, 8'h7F, 24'h800000, 1'b0, 8'h7F, 24'h800000, 24'h800000, 3'b000, 1};

    // Reset state
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst Er", 32'(Er), 32'd0);
    chk("rst GRS", 32'(GRS), 32'd0);
    #22 rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors with immediate handshake
    for (int i = 0; i < c_nvec; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d drop out_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d in_ready back", i), 32'(in_ready), 32'd1);
      chk($sformatf("vec%0d Er retained", i), 32'(Er), 32'(vecs[i].er));
    end

    // Backpressure: result held, second request ignored
    out_ready = 1'b0;
    run_op(vecs[0], "bp");
    for (int c = 0; c < 5; c++) begin
      Ea = vecs[1].ea; Ma = vecs[1].ma; Eb = vecs[1].eb; Mb = vecs[1].mb;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d Er", c), 32'(Er), 32'h80);
      chk($sformatf("bp%0d M_small", c), 32'(M_small), 32'h400000);
      chk($sformatf("bp%0d swap", c), 32'(swap), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release M_large", 32'(M_large), 32'hC00000);
    @(posedge clk); #1;
    chk("bp no phantom op", 32'(out_valid), 32'd0);

    // Reset asserted in the middle of a long shift
    launch(vecs[5], "rstmid");
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid in_ready", 32'(in_ready), 32'd0);
    chk("rstmid out_valid", 32'(out_valid), 32'd0);
    chk("rstmid Er", 32'(Er), 32'd0);
    chk("rstmid M_large", 32'(M_large), 32'd0);
    chk("rstmid M_small", 32'(M_small), 32'd0);
    chk("rstmid GRS", 32'(GRS), 32'd0);
    chk("rstmid swap", 32'(swap), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rstmid release in_ready", 32'(in_ready), 32'd1);
    chk("rstmid release out_valid", 32'(out_valid), 32'd0);
    run_op(vecs[1], "after_rst");
    @(posedge clk); #1;
    chk("after_rst idle", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/align_shifter.md
Name: align_shifter

Overview:
- Front-end operand alignment unit for the single-precision adder.
- Accepts two unpacked operands (biased exponent plus 24-bit mantissa with hidden bit) and orders them by magnitude.
- Right-shifts the smaller mantissa by the exponent difference, one bit per clock, and produces the guard/round/sticky triple that the adder and post-add normalization stage consume.
- Uses a valid/ready handshake on both sides. Holds one operation in flight.

Parameters:
MAX_SHIFT, 26, shift count at and beyond which the small mantissa is fully absorbed into sticky (single-cycle path)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
Ea  input  8  operand A biased exponent
Ma  input  24  operand A mantissa incl. hidden bit (0 for denormal)
Eb  input  8  operand B biased exponent
Mb  input  24  operand B mantissa incl. hidden bit
out_valid  output  1  aligned result valid
out_ready  input  1  downstream accepts result
Er  output  8  larger raw exponent
M_large  output  24  mantissa of larger-magnitude operand
M_small  output  24  aligned (shifted) mantissa of smaller operand
GRS  output  3  {guard, round, sticky} bits shifted out of M_small
swap  output  1  1 when B was selected as the larger operand

Behaviour:
- Reset (asynchronous assert, rst_n low): state goes to IDLE; all outputs are 0 except in_ready. in_ready is 1 once out of reset (it is 0 while rst_n is low). Assert mid-operation aborts the operation; no result is emitted.
- Effective exponent: eA = (Ea==0) ? 1 : Ea; likewise eB. It is used for comparison and difference only. Er is the raw exponent of the selected large operand, so both-zero gives Er = 0.
- Ordering: swap = 1 if eB > eA, or if eB == eA and Mb > Ma; otherwise swap = 0. On a full tie, swap = 0.
- Shift distance: d = |eA - eB|, unsigned 8-bit.
- States:
  - IDLE
  - SHIFT
  - DONE
- IDLE:
  - in_ready = 1. On in_valid && in_ready, register Er, M_large, M_small (unshifted), swap, GRS = 000 and cnt = d.
  - If d == 0, go to DONE.
  - If d >= MAX_SHIFT, set M_small = 0 and GRS = {0, 0, |smaller mantissa}, then go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: each cycle performs one bit shift:
  - S <= S | R
  - R <= G
  - G <= M_small[0]
  - M_small <= M_small >> 1
  - cnt <= cnt - 1
  - When cnt == 1 on that cycle, go to DONE.
- DONE:
  - out_valid = 1, with all result outputs stable.
  - On out_ready, go to IDLE; out_valid drops next cycle.
  - While out_ready = 0, hold indefinitely; in_ready = 0.
- Latency from accept edge to out_valid:
  - 1 cycle for d = 0 or d >= 26
  - 1 + d cycles for 1 <= d <= 25
- Throughput: one operation per (latency + 1) cycles minimum. There is no overlap between operations.
- Sticky equivalence: GRS must equal the result of an exact d-bit right shift of {M_small, 000}, with S = OR of all bits below R. This holds for every d, including 24 and 25, where G or R take mantissa MSBs.
- in_valid outside IDLE is ignored. Operand inputs only need to be stable on the accept cycle.
- Result outputs retain their last value in IDLE and change only on accept or during shifting. out_valid is the sole qualifier.

Test Plan:
- Ea=0x80, Ma=0xC00000, Eb=0x7F, Mb=0x800000, out_ready=1 -> swap=0, Er=0x80, M_large=0xC00000, M_small=0x400000, GRS=000, out_valid 2 cycles after accept.
- Ea=0x7F, Ma=0x800001, Eb=0x82, Mb=0x800000 -> swap=1, Er=0x82, M_large=0x800000, M_small=0x100000, GRS=001, latency 4.
- Ea=0x9E, Ma=0x800000, Eb=0x80, Mb=0x800003 (d=30) -> swap=0, M_small=0, GRS=001, latency 1.
- Tie then denormal case:
  - Ea=Eb=0x7F, Ma=0x800000, Mb=0xA00000 -> swap=1, GRS=000, latency 1.
  - Ea=0x00, Ma=0x400000, Eb=0x01, Mb=0x800000 -> d=0, swap=1, Er=0x01.
- Ea=0x98, Ma=0xFFFFFF, Eb=0x80, Mb=0xC00001 (d=24) -> M_small=0, GRS=111; latency 25.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is ignored.
  - Assert rst_n=0 during SHIFT -> all outputs 0 immediately.
  - After release -> in_ready=1, and a new operation completes correctly.
